// File: rtl/i2c_eeprom_slave.sv
// I2C slave emulating a 256-byte serial EEPROM at a fixed 7-bit bus address.
// Supports byte/sequential write, random, current-address and sequential read; never stretches SCL.
module i2c_eeprom_slave #(
  parameter logic [6:0] ADDRESS = 7'b101_0000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_pad_i,
  output logic       scl_pad_o,
  output logic       scl_padoen_o,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  input  logic [7:0] dbg_addr_i,
  output logic [7:0] dbg_data_o
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_DEV_ADDR  = 4'd1;
  localparam logic [3:0] S_DEV_ACK   = 4'd2;
  localparam logic [3:0] S_WADDR     = 4'd3;
  localparam logic [3:0] S_WADDR_ACK = 4'd4;
  localparam logic [3:0] S_WRITE     = 4'd5;
  localparam logic [3:0] S_WRITE_ACK = 4'd6;
  localparam logic [3:0] S_READ      = 4'd7;
  localparam logic [3:0] S_READ_ACK  = 4'd8;

  logic [1:0] scl_sync_reg;
  logic [1:0] sda_sync_reg;
  logic       scl_dly_reg;
  logic       sda_dly_reg;

  logic       scl_rise_reg;
  logic       scl_fall_reg;
  logic       start_reg;
  logic       stop_reg;
  logic       sda_smp_reg;

  logic [3:0] state_reg;
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic [7:0] tx_reg;
  logic       rw_reg;
  logic [7:0] ptr_reg;
  logic       sda_oe_reg;

  logic [7:0] mem [256];
  logic [7:0] rx_byte;
  logic       wr_en;

  assign scl_pad_o    = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = sda_oe_reg;
  assign dbg_data_o   = mem[dbg_addr_i];

  // Byte being completed on the current SCL rise (previous 7 bits plus the new one).
  assign rx_byte = {shift_reg[6:0], sda_smp_reg};
  assign wr_en   = scl_rise_reg && !start_reg && !stop_reg &&
                   (state_reg == S_WRITE) && (bit_cnt_reg == 3'd7);

  // Synchronizers idle high so reset release onto an idle bus creates no events.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
      scl_dly_reg  <= 1'b1;
      sda_dly_reg  <= 1'b1;
      scl_rise_reg <= 1'b0;
      scl_fall_reg <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
      sda_smp_reg  <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], scl_pad_i};
      sda_sync_reg <= {sda_sync_reg[0], sda_pad_i};
      scl_dly_reg  <= scl_sync_reg[1];
      sda_dly_reg  <= sda_sync_reg[1];
      scl_rise_reg <= scl_sync_reg[1] && !scl_dly_reg;
      scl_fall_reg <= !scl_sync_reg[1] && scl_dly_reg;
      start_reg    <= scl_sync_reg[1] && scl_dly_reg && !sda_sync_reg[1] && sda_dly_reg;
      stop_reg     <= scl_sync_reg[1] && scl_dly_reg && sda_sync_reg[1] && !sda_dly_reg;
      sda_smp_reg  <= sda_sync_reg[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'h00;
      tx_reg      <= 8'h00;
      rw_reg      <= 1'b0;
      ptr_reg     <= 8'h00;
      sda_oe_reg  <= 1'b1;
    end else if (start_reg) begin
      state_reg   <= S_DEV_ADDR;
      bit_cnt_reg <= 3'd0;
      sda_oe_reg  <= 1'b1;
    end else if (stop_reg) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= 3'd0;
      sda_oe_reg  <= 1'b1;
    end else if (scl_fall_reg) begin
      // Slave-driven bits change on SCL fall and hold until the following fall.
      case (state_reg)
        S_DEV_ACK, S_WADDR_ACK, S_WRITE_ACK: sda_oe_reg <= 1'b0;
        S_READ: begin
          sda_oe_reg <= tx_reg[7];
          tx_reg     <= {tx_reg[6:0], 1'b1};
        end
        default: sda_oe_reg <= 1'b1;
      endcase
    end else if (scl_rise_reg) begin
      case (state_reg)
        S_DEV_ADDR: begin
          shift_reg   <= rx_byte;
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            if (rx_byte[7:1] == ADDRESS) begin
              state_reg <= S_DEV_ACK;
              rw_reg    <= rx_byte[0];
            end else begin
              state_reg <= S_IDLE;
            end
          end
        end
        S_DEV_ACK: begin
          bit_cnt_reg <= 3'd0;
          if (rw_reg) begin
            state_reg <= S_READ;
            tx_reg    <= mem[ptr_reg];
          end else begin
            state_reg <= S_WADDR;
          end
        end
        S_WADDR: begin
          shift_reg   <= rx_byte;
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            ptr_reg   <= rx_byte;
            state_reg <= S_WADDR_ACK;
          end
        end
        S_WADDR_ACK: begin
          bit_cnt_reg <= 3'd0;
          state_reg   <= S_WRITE;
        end
        S_WRITE: begin
          shift_reg   <= rx_byte;
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            ptr_reg   <= ptr_reg + 8'd1;
            state_reg <= S_WRITE_ACK;
          end
        end
        S_WRITE_ACK: begin
          bit_cnt_reg <= 3'd0;
          state_reg   <= S_WRITE;
        end
        S_READ: begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_reg <= S_READ_ACK;
          end
        end
        S_READ_ACK: begin
          bit_cnt_reg <= 3'd0;
          // Master ACK continues the sequential read; NACK ends it with ptr on the last byte sent.
          if (!sda_smp_reg) begin
            ptr_reg   <= ptr_reg + 8'd1;
            tx_reg    <= mem[ptr_reg + 8'd1];
            state_reg <= S_READ;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        default: begin
          bit_cnt_reg <= 3'd0;
          state_reg   <= S_IDLE;
        end
      endcase
    end
  end

  // Register-based storage: every byte must clear on reset and the debug port reads combinationally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem[ptr_reg] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master, table vectors, directed corner cases
// and randomized traffic checked against a byte-array EEPROM model.
module tb_i2c_eeprom_slave;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] dbg_addr = 8'h00;
  logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
  logic [7:0] dbg_data;

  wire scl_bus = scl_m & (scl_padoen_o | scl_pad_o);
  wire sda_bus = sda_m & (sda_padoen_o | sda_pad_o);

  always #5 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .scl_pad_i    (scl_bus),
    .scl_pad_o    (scl_pad_o),
    .scl_padoen_o (scl_padoen_o),
    .sda_pad_i    (sda_bus),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .dbg_addr_i   (dbg_addr),
    .dbg_data_o   (dbg_data)
  );

  int vec_cnt = 0;
  int miss_cnt = 0;

  logic [7:0] mem_m [256];
  logic [7:0] ptr_m;

  typedef struct {
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    qwait();
    scl_m = 1'b1; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1;
    repeat (Q / 2) @(negedge clk);
    b = sda_bus;
    repeat (Q / 2) @(negedge clk);
    scl_m = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~master_ack);
  endtask

  task automatic check_dbg(input logic [7:0] a);
    dbg_addr = a;
    @(negedge clk);
    chk($sformatf("dbg[%02h]", a), dbg_data, mem_m[a]);
  endtask

  // Write n bytes (packed little-end first in data) starting at word address waddr.
  task automatic bus_write(input logic [7:0] waddr, input int n, input logic [31:0] data);
    logic ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, ack); chk("wr dev ack", ack, 1'b1);
    write_byte(waddr, ack); chk("wr waddr ack", ack, 1'b1);
    ptr_m = waddr;
    for (int i = 0; i < n; i++) begin
      d = data[8*i +: 8];
      write_byte(d, ack); chk("wr data ack", ack, 1'b1);
      mem_m[ptr_m] = d;
      ptr_m = ptr_m + 8'd1;
    end
    i2c_stop();
    check_dbg(waddr);
  endtask

  // Read n bytes; with set_addr the word address is written first followed by a repeated START.
  task automatic bus_read(input logic set_addr, input logic [7:0] waddr, input int n,
                          output logic [31:0] rd);
    logic ack;
    logic [7:0] d;
    rd = '0;
    if (set_addr) begin
      i2c_start();
      write_byte(8'hA0, ack); chk("rd dev ack", ack, 1'b1);
      write_byte(waddr, ack); chk("rd waddr ack", ack, 1'b1);
      ptr_m = waddr;
    end
    i2c_start();
    write_byte(8'hA1, ack); chk("rd devr ack", ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      read_byte(d, i < n - 1);
      chk($sformatf("rd data @%02h", ptr_m), d, mem_m[ptr_m]);
      rd[8*i +: 8] = d;
      if (i < n - 1) ptr_m = ptr_m + 8'd1;
    end
    chk("sda released after nack", sda_padoen_o, 1'b1);
    i2c_stop();
  endtask

  initial begin
    logic [31:0] rd;
    logic ack;
    logic oe_min;
    int op;
    logic [7:0] a;

    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    ptr_m = 8'h00;

    tbl[0] = '{waddr: 8'h10, wdata: 8'hA5, exp_rd: 8'hA5};
    tbl[1] = '{waddr: 8'h80, wdata: 8'hFF, exp_rd: 8'hFF};
    tbl[2] = '{waddr: 8'hFE, wdata: 8'h5A, exp_rd: 8'h5A};
    tbl[3] = '{waddr: 8'h7F, wdata: 8'h00, exp_rd: 8'h00};
    tbl[4] = '{waddr: 8'h40, wdata: 8'h3C, exp_rd: 8'h3C};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset sda_padoen", sda_padoen_o, 1'b1);
    chk("reset sda_pad", sda_pad_o, 1'b0);
    chk("reset scl_padoen", scl_padoen_o, 1'b1);
    chk("reset scl_pad", scl_pad_o, 1'b0);
    check_dbg(8'h10);

    // Table vectors: byte write then random read of the same word.
    for (int i = 0; i < 5; i++) begin
      bus_write(tbl[i].waddr, 1, {24'h0, tbl[i].wdata});
      bus_read(1'b1, tbl[i].waddr, 1, rd);
      chk("tbl readback", rd[7:0], tbl[i].exp_rd);
      dbg_addr = tbl[i].waddr;
      @(negedge clk);
      chk("tbl dbg", dbg_data, tbl[i].exp_rd);
    end

    // Sequential write wrapping past 0xFF, then current-address read at 0x02.
    bus_write(8'hFF, 3, 32'h0033_2211);
    dbg_addr = 8'hFF; @(negedge clk); chk("wrap mem[ff]", dbg_data, 8'h11);
    dbg_addr = 8'h00; @(negedge clk); chk("wrap mem[00]", dbg_data, 8'h22);
    dbg_addr = 8'h01; @(negedge clk); chk("wrap mem[01]", dbg_data, 8'h33);
    bus_read(1'b0, 8'h00, 1, rd);
    chk("current read after wrap", rd[7:0], 8'h00);

    // Sequential read across the wrap.
    bus_read(1'b1, 8'hFF, 3, rd);
    chk("seq read", rd[23:0], 24'h33_2211);

    // Address mismatch: no ACK on the 9th clock, following bytes ignored.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(1'(8'hA2 >> i));
    sda_m = 1'b1;
    oe_min = 1'b1;
    for (int i = 0; i < 3 * Q; i++) begin
      if (i == Q) scl_m = 1'b1;
      if (i == 2 * Q) scl_m = 1'b0;
      @(negedge clk);
      oe_min = oe_min & sda_padoen_o;
    end
    chk("mismatch 9th clk released", oe_min, 1'b1);
    write_byte(8'h10, ack); chk("mismatch later byte nack", ack, 1'b0);
    write_byte(8'h99, ack); chk("mismatch data nack", ack, 1'b0);
    i2c_stop();
    check_dbg(8'h10);

    // Abort: STOP after 4 bits of a data byte to 0x20.
    i2c_start();
    write_byte(8'hA0, ack); chk("abort dev ack", ack, 1'b1);
    write_byte(8'h20, ack); chk("abort waddr ack", ack, 1'b1);
    ptr_m = 8'h20;
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    chk("abort released", sda_padoen_o, 1'b1);
    check_dbg(8'h20);
    bus_read(1'b0, 8'h00, 1, rd);

    // Randomized traffic against the model.
    for (int t = 0; t < 25; t++) begin
      op = int'($urandom_range(0, 2));
      a = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
      case (op)
        0: bus_write(a, int'($urandom_range(1, 4)), $urandom);
        1: bus_read(1'b1, a, int'($urandom_range(1, 3)), rd);
        default: bus_read(1'b0, 8'h00, int'($urandom_range(1, 2)), rd);
      endcase
    end
    for (int i = 0; i < 4; i++) check_dbg(8'($urandom));

    // Reset asserted while the slave is pulling SDA low for the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(1'(8'hA0 >> i));
    sda_m = 1'b1;
    chk("ack being driven", sda_padoen_o, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset mid-ack releases", sda_padoen_o, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    ptr_m = 8'h00;
    scl_m = 1'b1; qwait();
    scl_m = 1'b0; qwait();
    i2c_stop();
    check_dbg(8'h10);
    check_dbg(8'hFF);
    check_dbg(8'h00);
    bus_read(1'b0, 8'h00, 1, rd);
    chk("post-reset current read", rd[7:0], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

Synthesizable I2C slave that emulates a 256-byte serial EEPROM at a fixed 7-bit bus address (default 0x50). It connects to an I2C bus through the standard open-drain pad triplet and serves as the on-chip or FPGA stand-in for an external EEPROM in the peripheral subsystem. It supports byte/sequential write, random read, current-address read and sequential read, with no clock stretching.

## Interface
- `ADDRESS`, default 7'b101_0000: 7-bit slave address that the block responds to.
- `clk_i`  in  1: system clock. Must run at ≥10× the SCL frequency.
- `rst_i`  in  1: reset. Synchronous, active-high.
- `scl_pad_i`  in  1: SCL bus level.
- `scl_pad_o`  out  1: SCL drive value. Constant 0.
- `scl_padoen_o`  out  1: SCL output enable, active-low. Constant 1, so the block never drives or stretches SCL.
- `sda_pad_i`  in  1: SDA bus level.
- `sda_pad_o`  out  1: SDA drive value. Constant 0.
- `sda_padoen_o`  out  1: SDA output enable, active-low. 0 pulls SDA low; 1 releases it.
- `dbg_addr_i`  in  8: backdoor read address.
- `dbg_data_o`  out  8: combinational `mem[dbg_addr_i]`.

## Operation
**Input sampling**
- SCL and SDA each pass through a 2-flop synchronizer, followed by a third flop used for edge detection.
- Events are derived from the synchronized and delayed samples:
  - SCL rise and SCL fall.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.

**Bit transfer**
- Data bits are sampled on SCL rise, MSB first.
- Slave-driven bits change on SCL fall.

**State machine**
- States: IDLE, DEV_ADDR, DEV_ACK, WADDR, WADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
- START in any state: go to DEV_ADDR with the bit counter at 0. This covers repeated START.
- STOP in any state: go to IDLE and release SDA.
- DEV_ADDR: shift in 8 bits.
  - Upper 7 bits == ADDRESS: go to DEV_ACK.
  - Otherwise: go to IDLE with no ACK. Ignore the bus until the next START.
- DEV_ACK: drive SDA low for the 9th clock.
  - R/W = 0: go to WADDR.
  - R/W = 1: go to READ, loading `mem[ptr]`.
- WADDR: shift in 8 bits, then `ptr <= byte`; go to WADDR_ACK, which ACKs and then goes to WRITE.
- WRITE: shift in 8 bits.
  - On the 8th SCL rise: `mem[ptr] <= byte` and `ptr <= ptr+1`.
  - Go to WRITE_ACK, which ACKs and returns to WRITE.
- READ: drive bits MSB first. SDA enable = bit value (bit 0 → pull low; bit 1 → release). After 8 bits, go to READ_ACK.
- READ_ACK: release SDA and sample the master's bit on the 9th SCL rise.
  - Low (ACK): `ptr <= ptr+1`, load `mem[ptr+1]`, return to READ.
  - High (NACK): go to IDLE.

**Address pointer and memory**
- `ptr` is 8 bits and wraps 0xFF → 0x00.
- `ptr` persists across transactions, which is what makes current-address read work.
- Random read = write of the word address, then repeated START, then read.
- Writing a word address without data bytes only updates `ptr`.

**SDA release**
- An ACK, or a driven read bit, is held from its SCL fall until the next SCL fall.
- On that fall SDA is released, unless the next slave-driven bit is 0.

## Timing
**Reset values**
- `sda_padoen_o`=1, `sda_pad_o`=0, `scl_padoen_o`=1, `scl_pad_o`=0.
- State IDLE, `ptr`=0x00, bit counter 0, all memory bytes 0x00.

**Latencies**
- Pad edge → internal event detection: 3 clk.
- `sda_padoen_o` is registered and changes 4 clk after the SCL fall on the pad.
  - This is well inside SCL low time given the clk ≥10× SCL requirement.
- Memory write takes effect on the clk after the detected 8th SCL rise. It is visible on `dbg_data_o` from then.

**Reset and abort**
- Reset asserted mid-transfer: `sda_padoen_o` goes to 1 on the next clk edge and all state is re-initialized.
- STOP mid-byte: discards the partial byte. Already-written bytes remain.

**Simultaneous events**
- START/STOP take priority over SCL-edge processing in the same clk.
- START and STOP in the same clk is impossible, because SDA has a single edge.

## Test plan
- **Byte write and readback.** Send START, 0xA0, 0x10, 0xA5, STOP. Then send START, 0xA0, 0x10, repeated START, 0xA1, read 1 byte with NACK, STOP.
  - Required: slave ACKs 0xA0, 0x10 and 0xA5 (and 0xA1).
  - Read returns 0xA5; `dbg_addr_i`=0x10 gives 0xA5.
- **Sequential write with wrap.** Write 0x11, 0x22, 0x33 starting at word address 0xFF.
  - Required: mem[0xFF]=0x11, mem[0x00]=0x22, mem[0x01]=0x33, `ptr`=0x02.
  - A following current-address read (0xA1) returns 0x00.
- **Sequential read.** Read 3 bytes from 0xFF, with master ACK, ACK, NACK.
  - Required: returns 0x11, 0x22, 0x33; SDA released after the NACK.
- **Address mismatch.** Send START, 0xA2.
  - Required: SDA stays released (`sda_padoen_o`=1) through the 9th clock; later bytes are ignored; memory is unchanged.
- **Abort.** Send STOP after 4 bits of a data byte to 0x20.
  - Required: mem[0x20] unchanged, state IDLE.
- **Reset mid-ACK.** Assert `rst_i` while the slave is pulling SDA low.
  - Required: `sda_padoen_o`=1 on the next clk, memory reads 0x00, `ptr`=0x00.
